// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 complex butterfly: out1 = in1 + in2*w, out2 = in1 - in2*w.
// Three register stages share one advance enable so bubbles and beats stall together.
module butterfly_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = DATA_WIDTH / 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in1_r,
    input  logic [DATA_WIDTH-1:0] in1_i,
    input  logic [DATA_WIDTH-1:0] in2_r,
    input  logic [DATA_WIDTH-1:0] in2_i,
    input  logic [DATA_WIDTH-1:0] w_r,
    input  logic [DATA_WIDTH-1:0] w_i,
    input  logic                  inv,
    input  logic                  scale,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out1_r,
    output logic [DATA_WIDTH-1:0] out1_i,
    output logic [DATA_WIDTH-1:0] out2_r,
    output logic [DATA_WIDTH-1:0] out2_i,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  ovf,
    input  logic                  clr_ovf
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 1;
    localparam int SW = 2 * W + 3;

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Conjugation widens w_i by one bit so negating the most negative value cannot wrap.
    logic [W:0] wi_ext;
    logic [W:0] wi_sel;
    assign wi_ext = {w_i[W-1], w_i};
    assign wi_sel = inv ? -wi_ext : wi_ext;

    logic                 v1;
    logic [W-1:0]         a1_r, a1_i, b1_r, b1_i, w1_r;
    logic [W:0]           w1_i;
    logic                 sc1;
    logic [TAG_WIDTH-1:0] tag1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1_r <= '0;
            a1_i <= '0;
            b1_r <= '0;
            b1_i <= '0;
            w1_r <= '0;
            w1_i <= '0;
            sc1  <= 1'b0;
            tag1 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1_r <= in1_r;
                a1_i <= in1_i;
                b1_r <= in2_r;
                b1_i <= in2_i;
                w1_r <= w_r;
                w1_i <= wi_sel;
                sc1  <= scale;
                tag1 <= tag_in;
            end
        end
    end

    logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
    assign br_x = {{(PW-W){b1_r[W-1]}}, b1_r};
    assign bi_x = {{(PW-W){b1_i[W-1]}}, b1_i};
    assign wr_x = {{(PW-W){w1_r[W-1]}}, w1_r};
    assign wi_x = {{(PW-W-1){w1_i[W]}}, w1_i};

    logic                 v2;
    logic signed [PW-1:0] p1, p2, p3, p4;
    logic [W-1:0]         a2_r, a2_i;
    logic                 sc2;
    logic [TAG_WIDTH-1:0] tag2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            p1   <= '0;
            p2   <= '0;
            p3   <= '0;
            p4   <= '0;
            a2_r <= '0;
            a2_i <= '0;
            sc2  <= 1'b0;
            tag2 <= '0;
        end else if (en) begin
            v2   <= v1;
            p1   <= br_x * wr_x;
            p2   <= bi_x * wi_x;
            p3   <= br_x * wi_x;
            p4   <= bi_x * wr_x;
            a2_r <= a1_r;
            a2_i <= a1_i;
            sc2  <= sc1;
            tag2 <= tag1;
        end
    end

    // Round half toward +inf, then clamp; the top bit of the result flags a clamp.
    function automatic logic [W:0] round_sat(input logic signed [SW-1:0] x, input logic sc);
        logic signed [SW-1:0] half;
        logic signed [SW-1:0] t;
        logic signed [SW-1:0] q;
        half = sc ? (SW'(1) << FRAC_BITS) : (SW'(1) << (FRAC_BITS - 1));
        t    = x + half;
        q    = sc ? (t >>> (FRAC_BITS + 1)) : (t >>> FRAC_BITS);
        if (q[SW-1:W-1] == {(SW-W+1){q[SW-1]}})
            return {1'b0, q[W-1:0]};
        else if (q[SW-1])
            return {1'b1, 1'b1, {(W-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(W-1){1'b1}}};
    endfunction

    logic signed [SW-1:0] ar_x, ai_x, p1_x, p2_x, p3_x, p4_x;
    logic signed [SW-1:0] s1r, s1i, s2r, s2i;
    logic [W:0]           r1r, r1i, r2r, r2i;
    logic                 sat_any;

    assign ar_x = {{(SW-W){a2_r[W-1]}}, a2_r} << FRAC_BITS;
    assign ai_x = {{(SW-W){a2_i[W-1]}}, a2_i} << FRAC_BITS;
    assign p1_x = {{(SW-PW){p1[PW-1]}}, p1};
    assign p2_x = {{(SW-PW){p2[PW-1]}}, p2};
    assign p3_x = {{(SW-PW){p3[PW-1]}}, p3};
    assign p4_x = {{(SW-PW){p4[PW-1]}}, p4};

    assign s1r = ar_x + p1_x - p2_x;
    assign s1i = ai_x + p3_x + p4_x;
    assign s2r = ar_x - p1_x + p2_x;
    assign s2i = ai_x - p3_x - p4_x;

    assign r1r     = round_sat(s1r, sc2);
    assign r1i     = round_sat(s1i, sc2);
    assign r2r     = round_sat(s2r, sc2);
    assign r2i     = round_sat(s2i, sc2);
    assign sat_any = r1r[W] | r1i[W] | r2r[W] | r2i[W];

    logic sat3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out1_r    <= '0;
            out1_i    <= '0;
            out2_r    <= '0;
            out2_i    <= '0;
            tag_out   <= '0;
            sat3      <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            out1_r    <= r1r[W-1:0];
            out1_i    <= r1i[W-1:0];
            out2_r    <= r2r[W-1:0];
            out2_i    <= r2i[W-1:0];
            tag_out   <= tag2;
            sat3      <= sat_any;
        end
    end

    // A saturated transfer beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (out_valid && out_ready && sat3)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vector table, hand-written
// handshake/ovf/reset sequences, and a randomized stream against a complex-arithmetic model.
module tb_butterfly_pipe;

    localparam int DW   = 16;
    localparam int FB   = 8;
    localparam int TW   = 5;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, in_valid, in_ready, inv, scale;
    logic                 out_valid, out_ready, ovf, clr_ovf;
    logic signed [DW-1:0] in1_r, in1_i, in2_r, in2_i, w_r, w_i;
    logic signed [DW-1:0] out1_r, out1_i, out2_r, out2_i;
    logic [TW-1:0]        tag_in, tag_out;

    int tests = 0;
    int fails = 0;

    butterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
        .w_r(w_r), .w_i(w_i), .inv(inv), .scale(scale), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out1_r(out1_r), .out1_i(out1_i), .out2_r(out2_r), .out2_i(out2_i),
        .tag_out(tag_out), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    typedef struct {
        int a_r, a_i, b_r, b_i, w_r, w_i;
        bit inv, scale;
        int tag;
        int e1r, e1i, e2r, e2i;
    } vec_t;

    typedef struct {
        int o1r, o1i, o2r, o2i;
        int tag;
        bit sat;
    } exp_t;

    task automatic checkOutput(input string name, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_valid = 1'b0; inv = 1'b0; scale = 1'b0; tag_in = '0;
        in1_r = '0; in1_i = '0; in2_r = '0; in2_i = '0; w_r = '0; w_i = '0;
    endtask

    // Drives one beat and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input vec_t v);
        int cnt;
        in1_r = DW'(v.a_r); in1_i = DW'(v.a_i);
        in2_r = DW'(v.b_r); in2_i = DW'(v.b_i);
        w_r   = DW'(v.w_r); w_i   = DW'(v.w_i);
        inv = v.inv; scale = v.scale; tag_in = TW'(v.tag);
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            step();
            cnt++;
        end
        if (!in_ready) checkOutput("accept_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic waitOut(input string name);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 10) begin
            step();
            cnt++;
        end
        if (!out_valid) checkOutput({name, "_out_timeout"}, 0, 1);
    endtask

    task automatic checkVec(input string name, input vec_t v);
        checkOutput({name, "_o1r"}, out1_r, v.e1r);
        checkOutput({name, "_o1i"}, out1_i, v.e1i);
        checkOutput({name, "_o2r"}, out2_r, v.e2r);
        checkOutput({name, "_o2i"}, out2_i, v.e2i);
        checkOutput({name, "_tag"}, tag_out, v.tag);
    endtask

    // Reference: exact complex multiply-accumulate, round half up, clamp.
    function automatic longint rnd(input longint x, input bit sc);
        int s;
        s = FB + int'(sc);
        return (x + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    function automatic int clip(input longint y);
        if (y > MAXV) return MAXV;
        if (y < MINV) return MINV;
        return int'(y);
    endfunction

    function automatic exp_t model(input int ar, ai, br, bi, wr, wi,
                                   input bit cj, sc, input int tag);
        exp_t   r;
        longint wim, pr, pim, base_r, base_i, y;
        wim    = cj ? -longint'(wi) : longint'(wi);
        pr     = longint'(br) * wr - longint'(bi) * wim;
        pim    = longint'(br) * wim + longint'(bi) * wr;
        base_r = longint'(ar) * (longint'(1) <<< FB);
        base_i = longint'(ai) * (longint'(1) <<< FB);
        r.sat  = 1'b0;
        r.tag  = tag;
        y = rnd(base_r + pr, sc);  r.o1r = clip(y); if (longint'(r.o1r) != y) r.sat = 1'b1;
        y = rnd(base_i + pim, sc); r.o1i = clip(y); if (longint'(r.o1i) != y) r.sat = 1'b1;
        y = rnd(base_r - pr, sc);  r.o2r = clip(y); if (longint'(r.o2r) != y) r.sat = 1'b1;
        y = rnd(base_i - pim, sc); r.o2i = clip(y); if (longint'(r.o2i) != y) r.sat = 1'b1;
        return r;
    endfunction

    function automatic int rval();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // Scoreboard monitor, active only during the randomized stream.
    bit   mon_en   = 1'b0;
    bit   exp_ovf  = 1'b0;
    int   accepted = 0;
    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("rnd_ovf", ovf, exp_ovf);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("rnd_unexpected_beat", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("rnd_o1r", out1_r, mon_e.o1r);
                    checkOutput("rnd_o1i", out1_i, mon_e.o1i);
                    checkOutput("rnd_o2r", out2_r, mon_e.o2r);
                    checkOutput("rnd_o2i", out2_i, mon_e.o2i);
                    checkOutput("rnd_tag", tag_out, mon_e.tag);
                    if (mon_e.sat) exp_ovf = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(int'(in1_r), int'(in1_i), int'(in2_r), int'(in2_i),
                                    int'(w_r), int'(w_i), inv, scale, int'(tag_in)));
                accepted++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    vec_t tbl[11];
    vec_t sat_v, id_v;

    initial begin
        int idx, nxt, stall, cyc;
        bit seen;
        logic signed [DW-1:0] snap_o1r;
        logic [TW-1:0] snap_tag;

        tbl[0]  = '{256, 0, 256, 0, 256, 0, 1'b0, 1'b0, 3, 512, 0, 0, 0};
        tbl[1]  = '{0, 0, 256, 0, 0, -256, 1'b0, 1'b0, 7, 0, -256, 0, 256};
        tbl[2]  = '{0, 0, 256, 0, 0, -256, 1'b1, 1'b0, 8, 0, 256, 0, -256};
        tbl[3]  = '{0, 0, 1, 0, 128, 0, 1'b0, 1'b0, 9, 1, 0, 0, 0};
        tbl[4]  = '{0, 0, -1, 0, 128, 0, 1'b0, 1'b0, 10, 0, 0, 1, 0};
        tbl[5]  = '{256, 0, 256, 0, 256, 0, 1'b0, 1'b1, 11, 256, 0, 0, 0};
        tbl[6]  = '{32767, 0, 256, 0, 256, 0, 1'b0, 1'b0, 12, 32767, 0, 32511, 0};
        tbl[7]  = '{-32768, 0, 256, 0, -256, 0, 1'b0, 1'b0, 13, -32768, 0, -32512, 0};
        tbl[8]  = '{0, 0, 256, 0, 0, -32768, 1'b1, 1'b0, 14, 0, 32767, 0, -32768};
        tbl[9]  = '{100, -50, 300, 200, 181, -181, 1'b0, 1'b0, 21, 454, -121, -254, 21};
        tbl[10] = '{100, -50, 300, 200, 181, -181, 1'b0, 1'b1, 22, 227, -60, -127, 10};
        sat_v   = tbl[6];
        id_v    = tbl[0];

        clearInputs();
        rst_n = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_o1r", out1_r, 0);
        checkOutput("rst_o2i", out2_i, 0);
        checkOutput("rst_tag", tag_out, 0);

        // Directed table; the first vector also pins the latency.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i]);
            if (i == 0) begin
                checkOutput("lat_edge_k", out_valid, 0);
                step();
                checkOutput("lat_edge_k1", out_valid, 0);
                step();
                checkOutput("lat_edge_k2", out_valid, 1);
            end else begin
                waitOut($sformatf("vec%0d", i));
            end
            checkVec($sformatf("vec%0d", i), tbl[i]);
        end
        repeat (4) step();

        // Sticky overflow: clear, non-saturating, saturating, clear, coincident set+clear.
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        checkOutput("ovf_cleared", ovf, 0);
        applyStimulus(id_v); waitOut("ovf_id"); step();
        checkOutput("ovf_nosat", ovf, 0);
        applyStimulus(sat_v); waitOut("ovf_sat");
        checkOutput("ovf_before_xfer", ovf, 0);
        step();
        checkOutput("ovf_after_xfer", ovf, 1);
        repeat (3) step();
        checkOutput("ovf_sticky", ovf, 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        checkOutput("ovf_clr_pulse", ovf, 0);
        applyStimulus(sat_v); waitOut("ovf_coinc");
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        checkOutput("ovf_set_wins", ovf, 1);
        repeat (2) step();

        // Reset with two beats in flight.
        clearInputs();
        in1_r = 16'sd500; tag_in = 5'd1; in_valid = 1'b1; step();
        tag_in = 5'd2; step();
        in_valid = 1'b0; rst_n = 1'b0; step(); rst_n = 1'b1;
        checkOutput("mrst_out_valid", out_valid, 0);
        checkOutput("mrst_o1r", out1_r, 0);
        checkOutput("mrst_o1i", out1_i, 0);
        checkOutput("mrst_o2r", out2_r, 0);
        checkOutput("mrst_tag", tag_out, 0);
        checkOutput("mrst_ovf", ovf, 0);
        checkOutput("mrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("mrst_no_stale", out_valid, 0);
        end

        // Backpressure: tags 0..5, out_ready low for 4 cycles once out_valid rises.
        clearInputs();
        idx = 0; nxt = 0; stall = 0; seen = 1'b0;
        snap_o1r = '0; snap_tag = '0;
        for (int c = 0; c < 40; c++) begin
            in_valid = (idx < 6);
            tag_in   = TW'(idx);
            in1_r    = DW'(idx * 10);
            if (out_valid) seen = 1'b1;
            out_ready = !(seen && stall < 4);
            @(negedge clk);
            if (!out_ready) begin
                stall++;
                checkOutput("bp_in_ready_low", in_ready, 0);
                checkOutput("bp_valid_held", out_valid, 1);
                if (stall == 1) begin
                    snap_o1r = out1_r;
                    snap_tag = tag_out;
                end else begin
                    checkOutput("bp_o1r_stable", out1_r, snap_o1r);
                    checkOutput("bp_tag_stable", tag_out, snap_tag);
                end
            end
            if (out_valid && out_ready) begin
                checkOutput("bp_tag_order", tag_out, nxt);
                checkOutput("bp_o1r", out1_r, nxt * 10);
                nxt++;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        checkOutput("bp_beats_out", nxt, 6);
        checkOutput("bp_stall_cycles", stall, 4);

        // Randomized stream with random backpressure against the model.
        clearInputs();
        out_ready = 1'b1;
        exp_ovf = 1'b0;
        mon_en = 1'b1;
        cyc = 0;
        while (accepted < 200 && cyc < 3000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in1_r = DW'(rval()); in1_i = DW'(rval());
            in2_r = DW'(rval()); in2_i = DW'(rval());
            w_r   = DW'(rval()); w_i   = DW'(rval());
            inv   = 1'($urandom_range(0, 1));
            scale = 1'($urandom_range(0, 1));
            tag_in = TW'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        mon_en = 1'b0;
        checkOutput("rnd_accepted", accepted, 200);
        checkOutput("rnd_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
